apb_multi_fifo: RTL and testbench

Parametrised successor to the team's single-channel APB FIFO. It holds NUM_CH independent synchronous FIFOs behind one AMBA 4 APB slave. Each channel has run-time depth selection, almost-full/almost-empty thresholds, flush, sticky error flags and PSLVERR reporting. Data reads are registered and use one wait state. The block sits on the peripheral APB as a CPU-visible buffer bank.

---
 rtl/apb_multi_fifo_pkg.sv | 41 ++++
 rtl/apb_fifo_channel.sv | 186 ++++++++++++++++++
 rtl/apb_multi_fifo.sv | 137 +++++++++++++
 tb/tb_apb_multi_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apb_multi_fifo_pkg.sv
// Shared definitions for the APB multi-channel FIFO bank: register offsets,
// register bit positions, the data-read FSM encoding and the depth check.
package apb_multi_fifo_pkg;

  // Byte offsets of the per-channel registers inside a 0x10 channel slot
  localparam logic [3:0] OFF_CFG      = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_THRESH   = 4'h8;
  localparam logic [3:0] OFF_IRQ_STAT = 4'hC;

  // CFG fields
  localparam int CFG_DEPTH_LSB  = 0;
  localparam int CFG_FLUSH_BIT  = 4;
  localparam int CFG_IRQ_EN_LSB = 8;

  // STATUS fields
  localparam int ST_EMPTY_BIT = 16;
  localparam int ST_FULL_BIT  = 17;
  localparam int ST_AF_BIT    = 18;
  localparam int ST_AE_BIT    = 19;

  // IRQ_STAT / IRQ_EN bit positions
  localparam int IRQ_OVF_BIT = 0;
  localparam int IRQ_UDF_BIT = 1;
  localparam int IRQ_AF_BIT  = 2;

  // Smallest supported channel depth is 8 entries
  localparam logic [3:0] DEPTH_LOG2_MIN = 4'd3;

  // Data reads take one wait state: the memory output is registered
  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  // A depth_log2 value is legal when 8 <= depth <= MAX_DEPTH
  function automatic logic depth_log2_ok(input logic [3:0] dl, input int max_log2);
    return (dl >= DEPTH_LOG2_MIN) && (int'(dl) <= max_log2);
  endfunction

endpackage

// File: rtl/apb_fifo_channel.sv
// One FIFO channel: storage, pointers, count, thresholds, flags and sticky
// status. Interrupt support (IRQ_EN / IRQ_STAT) exists only when the macro
// APB_MULTI_FIFO_IRQ_EN is defined.
module apb_fifo_channel
  import apb_multi_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             reg_we_i,
  input  logic [3:0]       reg_off_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       strb_i,
  input  logic             push_req_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_req_i,
  output logic [31:0]      reg_rdata_o,
  output logic             reg_err_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             irq_o
);

  localparam int AW = $clog2(MAX_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [MAX_DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       depth_log2_q, depth_log2_d;
  logic [10:0]      af_level_q, af_level_d, ae_level_q, ae_level_d;
  logic [AW-1:0]    depth_m1;
  logic [CW-1:0]    depth_cnt;
  logic [3:0]       new_dl;
  logic             cfg_wr, flush, do_push, do_pop;
  logic [2:0]       sticky_set, sticky_clr;

  assign depth_m1  = AW'((32'd1 << depth_log2_q) - 32'd1);
  assign depth_cnt = CW'(32'd1 << depth_log2_q);

  assign full_o         = (count_q == depth_cnt);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (11'(count_q) >= af_level_q);
  assign almost_empty_o = (11'(count_q) <= ae_level_q);

  // A CFG write with flush set only flushes; otherwise a depth change is
  // legal only for an in-range value on an empty channel.
  assign cfg_wr    = reg_we_i && (reg_off_i == OFF_CFG);
  assign new_dl    = wdata_i[CFG_DEPTH_LSB +: 4];
  assign flush     = cfg_wr && strb_i[0] && wdata_i[CFG_FLUSH_BIT];
  assign reg_err_o = (reg_off_i == OFF_CFG) && strb_i[0] && !wdata_i[CFG_FLUSH_BIT] &&
                     (!depth_log2_ok(new_dl, AW) || ((new_dl != depth_log2_q) && (count_q != '0)));

  assign do_push = push_req_i && !full_o;
  assign do_pop  = pop_req_i && !empty_o;

  assign sticky_set[IRQ_OVF_BIT] = push_req_i && full_o;
  assign sticky_set[IRQ_UDF_BIT] = pop_req_i && empty_o;
  assign sticky_clr = (reg_we_i && (reg_off_i == OFF_IRQ_STAT) && strb_i[0]) ? wdata_i[2:0] : 3'b000;

  // Next-state for pointers, count, depth and thresholds
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    depth_log2_d = depth_log2_q;
    af_level_d   = af_level_q;
    ae_level_d   = ae_level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == depth_m1) ? '0 : wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == depth_m1) ? '0 : rd_ptr_q + AW'(1);
        count_d  = count_q - CW'(1);
      end
      if (cfg_wr && strb_i[0] && !reg_err_o) depth_log2_d = new_dl;
    end
    if (reg_we_i && (reg_off_i == OFF_THRESH)) begin
      if (strb_i[0]) af_level_d[7:0]  = wdata_i[7:0];
      if (strb_i[1]) af_level_d[10:8] = wdata_i[10:8];
      if (strb_i[2]) ae_level_d[7:0]  = wdata_i[23:16];
      if (strb_i[3]) ae_level_d[10:8] = wdata_i[26:24];
    end
  end

  // Control and configuration state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      depth_log2_q <= DEPTH_LOG2_MIN;
      af_level_q   <= 11'(MAX_DEPTH - 1);
      ae_level_q   <= 11'd1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      depth_log2_q <= depth_log2_d;
      af_level_q   <= af_level_d;
      ae_level_q   <= ae_level_d;
    end
  end

  // Storage with registered read so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
    rdata_q <= mem[rd_ptr_q];
  end

  assign pop_data_o = rdata_q;

`ifdef APB_MULTI_FIFO_IRQ_EN
  logic [2:0] irq_en_q, irq_en_d, irq_stat_q, irq_stat_d;
  logic       af_prev_q;

  assign sticky_set[IRQ_AF_BIT] = almost_full_o && !af_prev_q;
  assign irq_en_d   = (cfg_wr && strb_i[1] && !flush && !reg_err_o) ?
                      wdata_i[CFG_IRQ_EN_LSB +: 3] : irq_en_q;
  // A new event wins over a simultaneous write-1-to-clear
  assign irq_stat_d = (irq_stat_q & ~sticky_clr) | sticky_set;
  assign irq_o      = |(irq_stat_q & irq_en_q);

  // Interrupt enable, sticky status and almost_full edge history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      af_prev_q  <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      af_prev_q  <= almost_full_o;
    end
  end
`else
  assign sticky_set[IRQ_AF_BIT] = 1'b0;
  assign irq_o = 1'b0;
`endif

  // Register read-back for the addressed offset
  always_comb begin
    reg_rdata_o = '0;
    case (reg_off_i)
      OFF_CFG: begin
        reg_rdata_o[CFG_DEPTH_LSB +: 4] = depth_log2_q;
`ifdef APB_MULTI_FIFO_IRQ_EN
        reg_rdata_o[CFG_IRQ_EN_LSB +: 3] = irq_en_q;
`endif
      end
      OFF_STATUS: begin
        reg_rdata_o[10:0]         = 11'(count_q);
        reg_rdata_o[ST_EMPTY_BIT] = empty_o;
        reg_rdata_o[ST_FULL_BIT]  = full_o;
        reg_rdata_o[ST_AF_BIT]    = almost_full_o;
        reg_rdata_o[ST_AE_BIT]    = almost_empty_o;
      end
      OFF_THRESH: begin
        reg_rdata_o[10:0]  = af_level_q;
        reg_rdata_o[26:16] = ae_level_q;
      end
      OFF_IRQ_STAT: begin
`ifdef APB_MULTI_FIFO_IRQ_EN
        reg_rdata_o[2:0] = irq_stat_q;
`endif
      end
      default: ;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{wdata_i, strb_i, sticky_set, sticky_clr};

endmodule

// File: rtl/apb_multi_fifo.sv
// APB slave fronting NUM_CH independent FIFO channels. Holds address decode,
// the one-wait-state data read FSM, the error/read-data mux and the irq OR.
// Optional interrupt logic is enabled by defining APB_MULTI_FIFO_IRQ_EN.
module apb_multi_fifo
  import apb_multi_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 256,
  parameter int NUM_CH    = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [31:0]       PADDR,
  input  logic [2:0]        PPROT,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] empty,
  output logic [NUM_CH-1:0] almost_full,
  output logic [NUM_CH-1:0] almost_empty,
  output logic              irq
);

  rd_state_e        state_q, state_d;
  logic [2:0]       ch_sel;
  logic             ch_ok, off_ok, access, rd_start, reg_acc, push_acc, pop_acc;
  logic [NUM_CH-1:0] reg_we, push_req, pop_req, ch_irq, ch_reg_err;
  logic [31:0]      ch_reg_rdata [NUM_CH];
  logic [WIDTH-1:0] ch_pop_data  [NUM_CH];
  logic             sel_full, sel_empty, sel_reg_err;
  logic [31:0]      sel_reg_rdata;
  logic [WIDTH-1:0] sel_pop_data;

  // Registers use a 0x10 slot per channel, data ports a 4-byte slot
  assign ch_sel = PADDR[31] ? PADDR[4:2] : PADDR[6:4];
  assign ch_ok  = (int'(ch_sel) < NUM_CH);
  assign off_ok = (PADDR[30:7] == '0) && (PADDR[1:0] == 2'b00);

  assign access   = PSEL && PENABLE;
  assign rd_start = (state_q == RD_IDLE) && access && !PWRITE && PADDR[31];
  assign reg_acc  = (state_q == RD_IDLE) && access && !PADDR[31];
  assign push_acc = (state_q == RD_IDLE) && access && PWRITE && PADDR[31];
  assign pop_acc  = (state_q == RD_WAIT) && access;
  assign PREADY   = !rd_start;

  // Read FSM: a data read spends one cycle waiting for the memory register
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (rd_start) state_d = RD_WAIT;
      RD_WAIT: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= RD_IDLE;
    else          state_q <= state_d;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign reg_we[gi]   = reg_acc && PWRITE && ch_ok && off_ok && (ch_sel == 3'(gi));
      assign push_req[gi] = push_acc && ch_ok && (ch_sel == 3'(gi));
      assign pop_req[gi]  = pop_acc && ch_ok && (ch_sel == 3'(gi));

      apb_fifo_channel #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH)
      ) u_ch (
        .clk_i          (PCLK),
        .rst_ni         (PRESETn),
        .reg_we_i       (reg_we[gi]),
        .reg_off_i      (PADDR[3:0]),
        .wdata_i        (PWDATA),
        .strb_i         (PSTRB),
        .push_req_i     (push_req[gi]),
        .push_data_i    (PWDATA[WIDTH-1:0]),
        .pop_req_i      (pop_req[gi]),
        .reg_rdata_o    (ch_reg_rdata[gi]),
        .reg_err_o      (ch_reg_err[gi]),
        .pop_data_o     (ch_pop_data[gi]),
        .full_o         (full[gi]),
        .empty_o        (empty[gi]),
        .almost_full_o  (almost_full[gi]),
        .almost_empty_o (almost_empty[gi]),
        .irq_o          (ch_irq[gi])
      );
    end
  endgenerate

  // Select the addressed channel's status and data
  always_comb begin
    sel_full      = 1'b0;
    sel_empty     = 1'b0;
    sel_reg_err   = 1'b0;
    sel_reg_rdata = '0;
    sel_pop_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) begin
        sel_full      = full[i];
        sel_empty     = empty[i];
        sel_reg_err   = ch_reg_err[i];
        sel_reg_rdata = ch_reg_rdata[i];
        sel_pop_data  = ch_pop_data[i];
      end
    end
  end

  // Response mux: PRDATA stays zero unless a read completes without error
  always_comb begin
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (reg_acc) begin
      PSLVERR = !ch_ok || !off_ok || (PWRITE && sel_reg_err);
      if (!PWRITE && !PSLVERR) PRDATA = sel_reg_rdata;
    end else if (push_acc) begin
      PSLVERR = !ch_ok || sel_full;
    end else if (pop_acc) begin
      PSLVERR = !ch_ok || sel_empty;
      if (!PSLVERR) PRDATA = 32'(sel_pop_data);
    end
  end

  assign irq = |ch_irq;

  logic unused_prot;
  assign unused_prot = ^PPROT;

endmodule

// File: tb/tb_apb_multi_fifo.sv
// Directed testbench for apb_multi_fifo (4 channels, 8-bit, 256 deep).
// Expectations follow APB_MULTI_FIFO_IRQ_EN when it is defined.
module tb_apb_multi_fifo;

  localparam int NUM_CH = 4;
`ifdef APB_MULTI_FIFO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [31:0]       PADDR, PWDATA, PRDATA;
  logic [2:0]        PPROT;
  logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR, irq;
  logic [3:0]        PSTRB;
  logic [NUM_CH-1:0] full, empty, almost_full, almost_empty;

  int n_checks = 0;
  int n_err    = 0;

  always #5 PCLK = ~PCLK;

  apb_multi_fifo #(.WIDTH(8), .MAX_DEPTH(256), .NUM_CH(NUM_CH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_a(input int ch, input logic [3:0] off);
    return 32'(ch * 16) | 32'(off);
  endfunction

  function automatic logic [31:0] data_a(input int ch);
    return 32'h8000_0000 | 32'(ch * 4);
  endfunction

  // One APB transfer; samples the response on the falling edge
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int waits);
    bit done;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0; done = 1'b0; rdata = '0; err = 1'b0;
    while (!done) begin
      @(negedge PCLK);
      if (PREADY) begin
        rdata = PRDATA; err = PSLVERR; done = 1'b1;
      end else begin
        check("prdata_zero_while_waiting", PRDATA, 32'h0);
        waits++;
        if (waits > 8) begin
          check("pready_timeout", 32'(waits), 32'd0);
          done = 1'b1;
        end
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("%s addr=%08h wdata=%08h rdata=%08h err=%0d waits=%0d",
             wr ? "WR" : "RD", addr, wdata, rdata, err, waits);
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic exp_err);
    logic [31:0] rd; logic err; int w;
    apb_xfer(1'b1, addr, data, strb, rd, err, w);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_waits);
    logic [31:0] rd; logic err; int w;
    apb_xfer(1'b0, addr, 32'h0, 4'h0, rd, err, w);
    check({tag, "_data"}, rd, exp_data);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_waits"}, 32'(w), 32'(exp_waits));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0; PPROT = 0;
    PRESETn = 1'b1;
    #2 PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready", 32'(PREADY), 32'd1);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_almost_empty", 32'(almost_empty), 32'hF);
    check("rst_full", 32'(full), 32'h0);
    check("rst_almost_full", 32'(almost_full), 32'h0);
    @(posedge PCLK); #1 PRESETn = 1'b1;

    rd_chk("rst_status0", reg_a(0, 4'h4), 32'h0009_0000, 1'b0, 0);
    rd_chk("rst_cfg0", reg_a(0, 4'h0), 32'h0000_0003, 1'b0, 0);
    rd_chk("rst_thresh0", reg_a(0, 4'h8), 32'h0001_00FF, 1'b0, 0);

    // ch1 at depth 8: fill, overflow, drain in order
    for (int i = 0; i < 8; i++) wr_chk($sformatf("push1_%0d", i), data_a(1), 32'hA0 + 32'(i), 4'hF, 1'b0);
    check("ch1_full_flag", 32'(full), 32'h2);
    wr_chk("push1_ovf", data_a(1), 32'hFF, 4'hF, 1'b1);
    rd_chk("status1_full", reg_a(1, 4'h4), 32'h0002_0008, 1'b0, 0);
    rd_chk("irqstat1_ovf", reg_a(1, 4'hC), IRQ_ON ? 32'h1 : 32'h0, 1'b0, 0);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("pop1_%0d", i), data_a(1), 32'hA0 + 32'(i), 1'b0, 1);
    check("ch1_drained_empty", 32'(empty), 32'hF);

    // ch2 pointer wrap at depth 8
    for (int i = 0; i < 6; i++) wr_chk($sformatf("push2a_%0d", i), data_a(2), 32'h10 + 32'(i), 4'hF, 1'b0);
    rd_chk("status2_six", reg_a(2, 4'h4), 32'h0000_0006, 1'b0, 0);
    for (int i = 0; i < 6; i++) rd_chk($sformatf("pop2a_%0d", i), data_a(2), 32'h10 + 32'(i), 1'b0, 1);
    for (int i = 0; i < 5; i++) wr_chk($sformatf("push2b_%0d", i), data_a(2), 32'h20 + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) rd_chk($sformatf("pop2b_%0d", i), data_a(2), 32'h20 + 32'(i), 1'b0, 1);
    rd_chk("status2_after_wrap", reg_a(2, 4'h4), 32'h0009_0000, 1'b0, 0);

    // ch3 underflow, interrupt enable and W1C
    rd_chk("pop3_udf", data_a(3), 32'h0, 1'b1, 1);
    rd_chk("irqstat3_udf", reg_a(3, 4'hC), IRQ_ON ? 32'h2 : 32'h0, 1'b0, 0);
    wr_chk("cfg3_irq_en", reg_a(3, 4'h0), 32'h0000_0203, 4'hF, 1'b0);
    check("irq_udf_enabled", 32'(irq), 32'(IRQ_ON));
    wr_chk("irqstat3_w1c", reg_a(3, 4'hC), 32'h2, 4'hF, 1'b0);
    check("irq_after_w1c", 32'(irq), 32'd0);
    rd_chk("irqstat3_cleared", reg_a(3, 4'hC), 32'h0, 1'b0, 0);
    rd_chk("cfg3_readback", reg_a(3, 4'h0), IRQ_ON ? 32'h203 : 32'h3, 1'b0, 0);

    // ch0 depth changes: refused while non-empty, flush wins, bounds checked
    for (int i = 0; i < 3; i++) wr_chk($sformatf("push0a_%0d", i), data_a(0), 32'h31 + 32'(i), 4'hF, 1'b0);
    wr_chk("cfg0_depth_busy", reg_a(0, 4'h0), 32'h4, 4'hF, 1'b1);
    rd_chk("cfg0_unchanged", reg_a(0, 4'h0), 32'h3, 1'b0, 0);
    wr_chk("cfg0_flush", reg_a(0, 4'h0), 32'h14, 4'hF, 1'b0);
    rd_chk("status0_flushed", reg_a(0, 4'h4), 32'h0009_0000, 1'b0, 0);
    rd_chk("cfg0_after_flush", reg_a(0, 4'h0), 32'h3, 1'b0, 0);
    wr_chk("cfg0_depth_low", reg_a(0, 4'h0), 32'h2, 4'hF, 1'b1);
    wr_chk("cfg0_depth_high", reg_a(0, 4'h0), 32'h9, 4'hF, 1'b1);
    wr_chk("cfg0_depth16", reg_a(0, 4'h0), 32'h4, 4'hF, 1'b0);
    rd_chk("cfg0_depth16_rb", reg_a(0, 4'h0), 32'h4, 1'b0, 0);

    // ch0 almost_full threshold and af_rise
    wr_chk("thresh0_af4", reg_a(0, 4'h8), 32'h0001_0004, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) wr_chk($sformatf("push0b_%0d", i), data_a(0), 32'h40 + 32'(i), 4'hF, 1'b0);
    check("af0_below", 32'(almost_full), 32'h0);
    wr_chk("push0b_3", data_a(0), 32'h43, 4'hF, 1'b0);
    check("af0_reached", 32'(almost_full), 32'h1);
    rd_chk("irqstat0_af_rise", reg_a(0, 4'hC), IRQ_ON ? 32'h4 : 32'h0, 1'b0, 0);
    rd_chk("status0_af", reg_a(0, 4'h4), 32'h0004_0004, 1'b0, 0);

    // Channel index NUM_CH and a misaligned offset are rejected without side effects
    rd_chk("bad_ch_reg_rd", reg_a(NUM_CH, 4'h4), 32'h0, 1'b1, 0);
    wr_chk("bad_ch_reg_wr", reg_a(NUM_CH, 4'h8), 32'h0000_0001, 4'hF, 1'b1);
    wr_chk("bad_ch_push", data_a(NUM_CH), 32'h55, 4'hF, 1'b1);
    rd_chk("bad_ch_pop", data_a(NUM_CH), 32'h0, 1'b1, 1);
    rd_chk("bad_offset", 32'h0000_0002, 32'h0, 1'b1, 0);
    rd_chk("status0_unchanged", reg_a(0, 4'h4), 32'h0004_0004, 1'b0, 0);
    check("empty_vec_final", 32'(empty), 32'hE);

    // Byte strobes: only the low THRESH byte changes
    wr_chk("thresh0_strb", reg_a(0, 4'h8), 32'hFFFF_FF07, 4'b0001, 1'b0);
    rd_chk("thresh0_strb_rb", reg_a(0, 4'h8), 32'h0001_0007, 1'b0, 0);
    check("af0_after_strb", 32'(almost_full), 32'h0);
    rd_chk("pop0_after_flush", data_a(0), 32'h40, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
